// File: rtl/vram_fill_arbiter.sv
// Arbitrates VRAM port A between CPU stores and a rectangle-fill engine.
// CPU stores always win; the fill engine consumes idle cycles and stalls in place.
module vram_fill_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FB_W   = 160,
  parameter int unsigned FB_H   = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_data,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  output logic              busy,
  output logic [31:0]       status_out
);

  typedef enum logic [1:0] {StIdle, StCheck, StRun} state_e;

  state_e state_q, state_d;

  // Programmable window
  logic [9:0]        org_x_q, org_x_d, size_w_q, size_w_d;
  logic [8:0]        org_y_q, org_y_d, size_h_q, size_h_d;
  logic [DATA_W-1:0] color_q, color_d;

  // Per-fill copies and walk counters
  logic [9:0]        w_q, w_d, col_q, col_d;
  logic [8:0]        h_q, h_d, row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, cur_q, cur_d;
  logic [DATA_W-1:0] fill_color_q, fill_color_d;

  logic              done_q, done_d, err_q, err_d;
  logic [15:0]       pix_q, pix_d;

  logic              vram_we_q, vram_we_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0] vram_din_q, vram_din_d;

  logic              ctrl_wr, start_cmd, abort_cmd, fill_issue, last_col, last_row;
  logic [10:0]       x_end, y_end;
  logic              unused_cfg;

  assign unused_cfg = ^{cfg_data[31:25], cfg_data[15:10]};

  assign ctrl_wr   = cfg_we && (cfg_sel == 2'd3);
  assign abort_cmd = ctrl_wr && cfg_data[1];
  assign start_cmd = ctrl_wr && cfg_data[0] && !cfg_data[1];

  // Widen before adding so an oversized rectangle cannot wrap past the check.
  assign x_end = 11'(org_x_q) + 11'(size_w_q);
  assign y_end = 11'(org_y_q) + 11'(size_h_q);

  assign last_col = (col_q == w_q - 10'd1);
  assign last_row = (row_q == h_q - 9'd1);

  // Next-state: config window, fill FSM and port-A mux
  always_comb begin
    state_d      = state_q;
    org_x_d      = org_x_q;
    org_y_d      = org_y_q;
    size_w_d     = size_w_q;
    size_h_d     = size_h_q;
    color_d      = color_q;
    w_d          = w_q;
    h_d          = h_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    cur_d        = cur_q;
    fill_color_d = fill_color_q;
    done_d       = done_q;
    err_d        = err_q;
    pix_d        = pix_q;
    fill_issue   = 1'b0;

    if (cfg_we) begin
      case (cfg_sel)
        2'd0: begin
          org_x_d = cfg_data[9:0];
          org_y_d = cfg_data[24:16];
        end
        2'd1: begin
          size_w_d = cfg_data[9:0];
          size_h_d = cfg_data[24:16];
        end
        2'd2:    color_d = cfg_data[DATA_W-1:0];
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (start_cmd) begin
          state_d = StCheck;
          done_d  = 1'b0;
          err_d   = 1'b0;
          pix_d   = 16'd0;
        end
      end
      StCheck: begin
        if (abort_cmd) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end else if (size_w_q == 10'd0 || size_h_q == 9'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (x_end > 11'(FB_W) || y_end > 11'(FB_H)) begin
          state_d = StIdle;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end else begin
          state_d      = StRun;
          w_d          = size_w_q;
          h_d          = size_h_q;
          fill_color_d = color_q;
          row_base_d   = ADDR_W'(32'(org_y_q) * FB_W + 32'(org_x_q));
          cur_d        = ADDR_W'(32'(org_y_q) * FB_W + 32'(org_x_q));
          col_d        = 10'd0;
          row_d        = 9'd0;
        end
      end
      StRun: begin
        if (abort_cmd) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end else if (!cpu_we) begin
          fill_issue = 1'b1;
          if (pix_q != 16'hFFFF) pix_d = pix_q + 16'd1;
          if (last_col) begin
            col_d      = 10'd0;
            row_d      = row_q + 9'd1;
            row_base_d = row_base_q + ADDR_W'(FB_W);
            cur_d      = row_base_q + ADDR_W'(FB_W);
            if (last_row) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            col_d = col_q + 10'd1;
            cur_d = cur_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    vram_we_d   = cpu_we || fill_issue;
    vram_addr_d = vram_addr_q;
    vram_din_d  = vram_din_q;
    if (cpu_we) begin
      vram_addr_d = cpu_addr;
      vram_din_d  = cpu_data;
    end else if (fill_issue) begin
      vram_addr_d = cur_q;
      vram_din_d  = fill_color_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      org_x_q      <= '0;
      org_y_q      <= '0;
      size_w_q     <= '0;
      size_h_q     <= '0;
      color_q      <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      cur_q        <= '0;
      fill_color_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pix_q        <= '0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_din_q   <= '0;
    end else begin
      state_q      <= state_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      size_w_q     <= size_w_d;
      size_h_q     <= size_h_d;
      color_q      <= color_d;
      w_q          <= w_d;
      h_q          <= h_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      cur_q        <= cur_d;
      fill_color_q <= fill_color_d;
      done_q       <= done_d;
      err_q        <= err_d;
      pix_q        <= pix_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_din_q   <= vram_din_d;
    end
  end

  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_din   = vram_din_q;
  assign busy       = (state_q != StIdle);
  assign status_out = {busy, done_q, err_q, 13'b0, pix_q};

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Directed bench for vram_fill_arbiter: CPU path, fills, contention, bounds, abort, reset.
module tb_vram_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        vram_we;
  logic [14:0] vram_addr;
  logic [7:0]  vram_din;
  logic        busy;
  logic [31:0] status_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vram_fill_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_din   (vram_din),
    .busy       (busy),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_wr(input string tag, input logic we, input logic [14:0] addr,
                           input logic [7:0] data);
    check(tag, {8'd0, vram_we, vram_addr, vram_din}, {8'd0, we, addr, data});
  endtask

  task automatic expect_no_wr(input string tag);
    check(tag, {31'd0, vram_we}, 32'd0);
  endtask

  // One-cycle register write; returns in the cycle after the strobe.
  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  logic [14:0] basic_addr [8];

  initial begin
    basic_addr = '{15'd482, 15'd483, 15'd484, 15'd485, 15'd642, 15'd643, 15'd644, 15'd645};
    rst = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    tick(); tick();
    rst = 1'b0;

    expect_wr("reset_vram", 1'b0, 15'd0, 8'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_status", status_out, 32'd0);

    // Plain CPU store in idle: one cycle latency.
    cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_data = 8'hA5;
    tick();
    cpu_we = 1'b0;
    expect_wr("cpu_idle_store", 1'b1, 15'h1234, 8'hA5);
    tick();
    expect_no_wr("cpu_idle_after");

    // Basic 4x2 fill at (2,3).
    cfg_write(2'd0, 32'h0003_0002);
    cfg_write(2'd1, 32'h0002_0004);
    cfg_write(2'd2, 32'h0000_005A);
    cfg_write(2'd3, 32'h0000_0001);
    check("basic_check_busy", status_out, 32'h8000_0000);
    expect_no_wr("basic_check_nowr");
    tick();
    expect_no_wr("basic_run_nowr");
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_wr("basic_fill", 1'b1, basic_addr[i], 8'h5A);
    end
    check("basic_done_status", status_out, 32'h4000_0008);
    tick();
    expect_no_wr("basic_after");

    // Same fill with two CPU stores stalling it.
    cfg_write(2'd3, 32'h0000_0001);
    tick();
    tick();
    expect_wr("cont_fill0", 1'b1, 15'd482, 8'h5A);
    tick();
    expect_wr("cont_fill1", 1'b1, 15'd483, 8'h5A);
    cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_data = 8'hFF;
    tick();
    expect_wr("cont_cpu0", 1'b1, 15'h0100, 8'hFF);
    tick();
    cpu_we = 1'b0;
    expect_wr("cont_cpu1", 1'b1, 15'h0100, 8'hFF);
    check("cont_busy_stalled", {31'd0, busy}, 32'd1);
    for (int i = 2; i < 8; i++) begin
      tick();
      expect_wr("cont_fill", 1'b1, basic_addr[i], 8'h5A);
    end
    check("cont_done_status", status_out, 32'h4000_0008);

    // Out-of-bounds rectangle: x=150 w=11 exceeds 160.
    cfg_write(2'd0, 32'h0000_0096);
    cfg_write(2'd1, 32'h0001_000B);
    cfg_write(2'd3, 32'h0000_0001);
    check("bounds_check_status", status_out, 32'h8000_0000);
    expect_no_wr("bounds_nowr0");
    tick();
    check("bounds_err_status", status_out, 32'h2000_0000);
    expect_no_wr("bounds_nowr1");
    tick();
    expect_no_wr("bounds_nowr2");

    // Zero height: completes immediately with no writes.
    cfg_write(2'd1, 32'h0000_0004);
    cfg_write(2'd3, 32'h0000_0001);
    expect_no_wr("zero_nowr0");
    tick();
    check("zero_status", status_out, 32'h4000_0000);
    expect_no_wr("zero_nowr1");

    // 10x10 fill at origin, aborted after the fifth write.
    cfg_write(2'd0, 32'h0000_0000);
    cfg_write(2'd1, 32'h000A_000A);
    cfg_write(2'd2, 32'h0000_0033);
    cfg_write(2'd3, 32'h0000_0001);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_wr("abort_fill", 1'b1, 15'(i), 8'h33);
    end
    cfg_write(2'd3, 32'h0000_0002);
    expect_no_wr("abort_nowr0");
    check("abort_status", status_out, 32'h0000_0005);
    tick();
    expect_no_wr("abort_nowr1");

    // Full 10x10 run; an ORG write mid-fill must not disturb it.
    cfg_write(2'd3, 32'h0000_0001);
    tick();
    for (int i = 0; i < 100; i++) begin
      tick();
      expect_wr("full_fill", 1'b1, 15'((i / 10) * 160 + (i % 10)), 8'h33);
      if (i == 10) begin
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'h0005_0005;
      end else if (i == 11) begin
        cfg_we = 1'b0;
      end
    end
    check("full_done_status", status_out, 32'h4000_0064);

    // Reset while running loses the fill.
    cfg_write(2'd3, 32'h0000_0001);
    tick();
    tick();
    expect_wr("rst_fill0", 1'b1, 15'd805, 8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_wr("rst_vram", 1'b0, 15'd0, 8'd0);
    check("rst_status", status_out, 32'd0);

    // Start and abort together: abort wins.
    cfg_write(2'd1, 32'h0002_0002);
    cfg_write(2'd3, 32'h0000_0003);
    for (int i = 0; i < 4; i++) begin
      check("startabort_idle", {31'd0, busy}, 32'd0);
      expect_no_wr("startabort_nowr");
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
